// File: rtl/shift_rows_stream.sv
// shift_rows_stream: byte-serial ShiftRows / InvShiftRows engine.
// Accepts one state byte per cycle in column-major order, collects a full
// block in one bank of a two-bank ping-pong store, and replays it row-shifted
// from that bank while the other bank fills. The mode is captured per block.
module shift_rows_stream #(
  parameter int NB = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_inv,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  localparam int BYTES = 4 * NB;
  localparam int IW    = $clog2(BYTES);
  localparam int CW    = IW - 2;
  localparam int S2    = (NB == 8) ? 3 : 2;
  localparam int S3    = (NB == 8) ? 4 : 3;

  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  localparam logic [CW:0]   NB_W     = (CW + 1)'(NB);

  if (NB != 4 && NB != 6 && NB != 8) begin : gen_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  logic [7:0]    mem_q [2][BYTES];
  logic [7:0]    mem_d [2][BYTES];
  logic [1:0]    full_q, full_d;
  logic [1:0]    inv_q, inv_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;

  logic          wr_fire;
  logic          rd_fire;
  logic [1:0]    row;
  logic [CW-1:0] col;
  logic [CW:0]   shift_amt;
  logic [CW:0]   col_sum;
  logic [IW-1:0] src_idx;

  // Handshake flags come straight from the full flags so in_ready never
  // sees out_ready combinationally.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign out_data  = mem_q[rd_bank_q][src_idx];
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);

  // Map the output position to its source byte: rotate the column by the row
  // offset and wrap modulo NB with one compare-and-subtract.
  always_comb begin
    row = rd_idx_q[1:0];
    col = rd_idx_q[IW-1:2];
    case (row)
      2'd0:    shift_amt = '0;
      2'd1:    shift_amt = (CW + 1)'(1);
      2'd2:    shift_amt = (CW + 1)'(S2);
      default: shift_amt = (CW + 1)'(S3);
    endcase
    if (inv_q[rd_bank_q]) begin
      col_sum = (CW + 1)'(col) + (NB_W - shift_amt);
    end else begin
      col_sum = (CW + 1)'(col) + shift_amt;
    end
    if (col_sum >= NB_W) begin
      col_sum = col_sum - NB_W;
    end
    src_idx = {col_sum[CW-1:0], row};
  end

  // Next-state for storage, bank flags and both pointers; a fill completing on
  // one bank and a drain completing on the other are applied together.
  always_comb begin
    mem_d     = mem_q;
    full_d    = full_q;
    inv_d     = inv_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;

    if (wr_fire) begin
      mem_d[wr_bank_q][wr_idx_q] = in_data;
      if (wr_idx_q == '0) begin
        inv_d[wr_bank_q] = in_inv;
      end
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + IW'(1);
      end
    end

    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end
  end

  // State registers; reset discards any partial or buffered block and clears
  // storage so out_data reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < BYTES; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      full_q    <= '0;
      inv_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      full_q    <= full_d;
      inv_q     <= inv_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: scoreboard bench for shift_rows_stream at NB=4 and NB=8.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       in_inv;
  logic [7:0] in_data;
  logic       out_ready;
  logic       sel8;

  logic       in_valid4, in_ready4, out_valid4, out_last4;
  logic [7:0] out_data4;
  logic       in_valid8, in_ready8, out_valid8, out_last8;
  logic [7:0] out_data8;
  logic       cur_in_ready;

  assign in_valid4    = in_valid & ~sel8;
  assign in_valid8    = in_valid & sel8;
  assign cur_in_ready = sel8 ? in_ready8 : in_ready4;

  shift_rows_stream #(.NB(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4)
  );

  shift_rows_stream #(.NB(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_last(out_last8)
  );

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] din[16];
    logic       inv;
    logic [7:0] dout[16];
  } vec_t;

  exp_t   q4[$];
  exp_t   q8[$];
  vec_t   vecs[4];

  int     checks = 0;
  int     passes = 0;
  int     fails = 0;
  int     accepted = 0;
  int     stalls = 0;
  longint last_accept_time = 0;
  longint mon_first_time = -1;
  longint mon_last_time = 0;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) begin
      passes++;
    end else begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference mapping written straight from the row-offset definition.
  function automatic void shiftModel(input logic [7:0] blk[32], input int nb, input logic inv,
                                     output logic [7:0] res[32]);
    int s;
    int sc;
    for (int i = 0; i < 32; i++) res[i] = 8'h00;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        case (r)
          0: s = 0;
          1: s = 1;
          2: s = (nb == 8) ? 3 : 2;
          default: s = (nb == 8) ? 4 : 3;
        endcase
        sc = inv ? ((c - s + nb) % nb) : ((c + s) % nb);
        res[c*4 + r] = blk[sc*4 + r];
      end
    end
  endfunction

  // Present one byte and hold it until the engine takes it.
  task automatic sendByte(input logic [7:0] d, input logic inv, output logic ok);
    int budget = 0;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    while (!cur_in_ready && budget < 300) begin
      @(negedge clk);
      budget++;
      stalls++;
    end
    if (budget >= 300) begin
      checkOutput("in_ready_timeout", 32'(budget), 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_accept_time = $time;
    accepted++;
    ok = 1'b1;
  endtask

  // Queue the expected block and stream its input; non-first bytes carry the
  // opposite mode so a late mode sample would show up.
  task automatic applyStimulus(input logic [7:0] blk[32], input logic [7:0] want[32],
                               input int n, input logic inv);
    logic ok;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.data = want[k];
      e.last = (k == n - 1);
      if (sel8) q8.push_back(e);
      else      q4.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      sendByte(blk[k], (k == 0) ? inv : ~inv, ok);
      if (!ok) return;
    end
  endtask

  task automatic idleInput();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int b = 0;
    while ((q4.size() != 0 || q8.size() != 0) && b < 600) begin
      @(negedge clk);
      b++;
    end
    if (b >= 600) checkOutput(name, 32'(q4.size() + q8.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard for the NB=4 instance: every byte that fires must match the head.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready) begin
      if (q4.size() == 0) begin
        checkOutput("sb4_extra_byte", 32'(q4.size()), 32'd1);
      end else begin
        exp_t e;
        e = q4.pop_front();
        checkOutput("sb4_byte", {23'd0, out_last4, out_data4}, {23'd0, e.last, e.data});
        if (mon_first_time < 0) mon_first_time = $time;
        mon_last_time = $time;
      end
    end
  end

  // Scoreboard for the NB=8 instance.
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready) begin
      if (q8.size() == 0) begin
        checkOutput("sb8_extra_byte", 32'(q8.size()), 32'd1);
      end else begin
        exp_t e;
        e = q8.pop_front();
        checkOutput("sb8_byte", {23'd0, out_last8, out_data8}, {23'd0, e.last, e.data});
        if (mon_first_time < 0) mon_first_time = $time;
        mon_last_time = $time;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0] blk[32];
  logic [7:0] want[32];
  logic [7:0] blk_b[32];
  logic [7:0] want_b[32];
  logic [7:0] blk_c[32];
  logic [7:0] want_c[32];
  logic       ok;
  int         stall_base;
  int         acc_base;
  int         stable_bad;
  logic       held_set;
  logic [7:0] held_d;
  logic       held_l;

  initial begin
    vecs[0].din  = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,
                     8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
    vecs[0].inv  = 1'b0;
    vecs[0].dout = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,
                     8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
    for (int i = 0; i < 16; i++) vecs[1].din[i] = 8'(i);
    vecs[1].inv  = 1'b0;
    vecs[1].dout = '{8'h00,8'h05,8'h0a,8'h0f,8'h04,8'h09,8'h0e,8'h03,
                     8'h08,8'h0d,8'h02,8'h07,8'h0c,8'h01,8'h06,8'h0b};
    for (int i = 0; i < 16; i++) vecs[2].din[i] = 8'(i);
    vecs[2].inv  = 1'b1;
    vecs[2].dout = '{8'h00,8'h0d,8'h0a,8'h07,8'h04,8'h01,8'h0e,8'h0b,
                     8'h08,8'h05,8'h02,8'h0f,8'h0c,8'h09,8'h06,8'h03};
    vecs[3].din  = vecs[1].dout;
    vecs[3].inv  = 1'b1;
    for (int i = 0; i < 16; i++) vecs[3].dout[i] = 8'(i);

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; sel8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready",  32'(in_ready4),  32'd1);
    checkOutput("reset_out_valid", 32'(out_valid4), 32'd0);
    checkOutput("reset_out_data",  32'(out_data4),  32'd0);
    checkOutput("reset_out_last",  32'(out_last4),  32'd0);
    checkOutput("reset_out_valid8", 32'(out_valid8), 32'd0);

    @(posedge clk); #1 out_ready = 1'b1;

    // Known-answer vectors, each followed by a latency check.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 32; i++) begin
        blk[i]  = (i < 16) ? vecs[v].din[i]  : 8'h00;
        want[i] = (i < 16) ? vecs[v].dout[i] : 8'h00;
      end
      mon_first_time = -1;
      applyStimulus(blk, want, 16, vecs[v].inv);
      idleInput();
      waitDrain("table_drain");
      checkOutput("table_latency", 32'(mon_first_time - last_accept_time), 32'd5);
    end

    // Three back-to-back blocks with alternating mode and no bubbles.
    stall_base = stalls;
    mon_first_time = -1;
    for (int bnum = 0; bnum < 3; bnum++) begin
      for (int i = 0; i < 32; i++) blk[i] = 8'($urandom_range(0, 255));
      shiftModel(blk, 4, bnum[0], want);
      applyStimulus(blk, want, 16, bnum[0]);
    end
    idleInput();
    waitDrain("stream_drain");
    checkOutput("stream_in_stalls", 32'(stalls - stall_base), 32'd0);
    checkOutput("stream_out_span", 32'(mon_last_time - mon_first_time), 32'd470);

    // Backpressure: out_ready low for 40 cycles while three blocks are offered.
    for (int i = 0; i < 32; i++) begin
      blk[i]   = 8'($urandom_range(0, 255));
      blk_b[i] = 8'($urandom_range(0, 255));
      blk_c[i] = 8'($urandom_range(0, 255));
    end
    shiftModel(blk, 4, 1'b0, want);
    shiftModel(blk_b, 4, 1'b1, want_b);
    shiftModel(blk_c, 4, 1'b0, want_c);
    @(posedge clk); #1 out_ready = 1'b0;
    acc_base = accepted;
    stable_bad = 0;
    held_set = 1'b0;
    held_d = 8'h00;
    held_l = 1'b0;
    fork
      begin
        applyStimulus(blk, want, 16, 1'b0);
        applyStimulus(blk_b, want_b, 16, 1'b1);
        applyStimulus(blk_c, want_c, 16, 1'b0);
        idleInput();
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (out_valid4) begin
            if (!held_set) begin
              held_set = 1'b1;
              held_d = out_data4;
              held_l = out_last4;
            end else if (out_data4 !== held_d || out_last4 !== held_l) begin
              stable_bad++;
            end
          end
        end
        checkOutput("bp_accepted", 32'(accepted - acc_base), 32'd32);
        checkOutput("bp_in_ready", 32'(in_ready4), 32'd0);
        checkOutput("bp_stable", 32'(stable_bad), 32'd0);
        checkOutput("bp_held_byte", 32'(held_d), 32'(want[0]));
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    waitDrain("bp_drain");

    // Reset while block 1 drains and block 2 is partly written.
    for (int i = 0; i < 32; i++) blk[i] = 8'($urandom_range(0, 255));
    shiftModel(blk, 4, 1'b1, want);
    applyStimulus(blk, want, 16, 1'b1);
    for (int k = 0; k < 7; k++) sendByte(8'($urandom_range(1, 255)), 1'b0, ok);
    idleInput();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q4.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid4), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready4),  32'd1);
    checkOutput("midrst_out_data",  32'(out_data4),  32'd0);
    for (int i = 0; i < 32; i++) begin
      blk[i]  = (i < 16) ? vecs[0].din[i]  : 8'h00;
      want[i] = (i < 16) ? vecs[0].dout[i] : 8'h00;
    end
    applyStimulus(blk, want, 16, 1'b0);
    idleInput();
    waitDrain("midrst_drain");

    // NB=8: forward block with the wrap columns pinned, then an inverse block.
    sel8 = 1'b1;
    for (int i = 0; i < 32; i++) blk[i] = 8'(i);
    shiftModel(blk, 8, 1'b0, want);
    want[0]  = 8'h00; want[1]  = 8'h05; want[2]  = 8'h0e; want[3]  = 8'h13;
    want[28] = 8'h1c; want[29] = 8'h01; want[30] = 8'h0a; want[31] = 8'h0f;
    applyStimulus(blk, want, 32, 1'b0);
    for (int i = 0; i < 32; i++) blk_b[i] = 8'($urandom_range(0, 255));
    shiftModel(blk_b, 8, 1'b1, want_b);
    applyStimulus(blk_b, want_b, 32, 1'b1);
    idleInput();
    waitDrain("nb8_drain");

    checkOutput("sb_empty", 32'(q4.size() + q8.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
